// File: rtl/scarf_edge_gate_sequencer.sv
// ---------------------------------------------------------------------------
// scarf_edge_gate_sequencer
//
// Drives the enables of the two GPIO edge counters through repeatable timed
// measurement windows. Each window runs:
//    ARM (1 cycle, enables low so the counters clear)
//    GATE (max(cfg_window,1) cycles, enables = latched channel mask)
//    SETTLE (SETTLE_CYCLES cycles, lets the counter pipeline drain)
//    CAPTURE (1 cycle, pushes {count_1, count_0} into the snapshot FIFO)
//    GAP (cfg_gap cycles, skipped when cfg_gap is 0)
// After the programmed number of windows, one DONE cycle pulses done.
//
// Parameters
//    SETTLE_CYCLES  cycles between gate close and capture (>= 1)
//    FIFO_DEPTH     snapshot FIFO entries (power of two, >= 2)
//
// Ports
//    clk, rst_sync       clock, synchronous active-high reset
//    start, abort        run control pulses (abort wins over start)
//    cfg_chan_en/window/gap/repeat   run configuration, latched at start
//    count_0, count_1    count values from the edge counters
//    counter_enable      enables to the edge counters (registered)
//    busy, done          run status; done pulses once on normal completion
//    window_idx          windows captured in the current run
//    fifo_rd             pop the head FIFO entry
//    fifo_rd_data        head entry {count_1, count_0}
//    fifo_rd_ts          head entry gate-entry timestamp (optional)
//    fifo_empty/full     FIFO status
//    overflow            sticky, a capture was dropped on a full FIFO
//
// Optional feature macro: EDGE_GATE_TIMESTAMP_EN
//    When defined, a free-running 32-bit cycle counter is sampled at every
//    GATE entry and stored alongside the counts; fifo_rd_ts presents it.
// ---------------------------------------------------------------------------
module scarf_edge_gate_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  cfg_chan_en,
    input  logic [31:0] cfg_window,
    input  logic [15:0] cfg_gap,
    input  logic [7:0]  cfg_repeat,
    input  logic [31:0] count_0,
    input  logic [31:0] count_1,
    output logic [1:0]  counter_enable,
    output logic        busy,
    output logic        done,
    output logic [7:0]  window_idx,
    input  logic        fifo_rd,
    output logic [63:0] fifo_rd_data,
`ifdef EDGE_GATE_TIMESTAMP_EN
    output logic [31:0] fifo_rd_ts,
`endif
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
`ifdef EDGE_GATE_TIMESTAMP_EN
    localparam int EW = 96;
`else
    localparam int EW = 64;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GATE,
        SETTLE,
        CAPTURE,
        GAP,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    chan_en_q;
    logic [31:0]   window_q;
    logic [15:0]   gap_q;
    logic [7:0]    repeat_q;
    logic [31:0]   gate_cnt;
    logic [SW-1:0] settle_cnt;
    logic [15:0]   gap_cnt;

    logic          start_accept;
    logic          push_req;
    logic          last_window;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [EW-1:0] head;
    logic [EW-1:0] push_entry;
    logic          pop;
    logic          do_push;

    // abort outranks start; a capture cut short by abort never pushes
    assign start_accept = (state == IDLE) && start && !abort;
    assign push_req     = (state == CAPTURE) && !abort;
    assign last_window  = (repeat_q != 8'd0) && ((window_idx + 8'd1) == repeat_q);

    // Sequencer FSM. Every output is registered and set on the same edge
    // that enters the state it belongs to, so it tracks the state exactly.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state          <= IDLE;
            counter_enable <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b0;
            window_idx     <= 8'd0;
            chan_en_q      <= 2'b00;
            window_q       <= 32'd0;
            gap_q          <= 16'd0;
            repeat_q       <= 8'd0;
            gate_cnt       <= 32'd0;
            settle_cnt     <= '0;
            gap_cnt        <= 16'd0;
        end else if (abort) begin
            state          <= IDLE;
            counter_enable <= 2'b00;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        chan_en_q  <= cfg_chan_en;
                        window_q   <= cfg_window;
                        gap_q      <= cfg_gap;
                        repeat_q   <= cfg_repeat;
                        window_idx <= 8'd0;
                        busy       <= 1'b1;
                        state      <= ARM;
                    end
                end
                ARM: begin
                    // a zero window still gates for one cycle
                    gate_cnt       <= (window_q == 32'd0) ? 32'd0 : window_q - 32'd1;
                    counter_enable <= chan_en_q;
                    state          <= GATE;
                end
                GATE: begin
                    if (gate_cnt == 32'd0) begin
                        counter_enable <= 2'b00;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= SETTLE;
                    end else begin
                        gate_cnt <= gate_cnt - 32'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    window_idx <= window_idx + 8'd1;
                    if (last_window) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (gap_q == 16'd0) begin
                        state <= ARM;
                    end else begin
                        gap_cnt <= gap_q - 16'd1;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state <= ARM;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    counter_enable <= 2'b00;
                    busy           <= 1'b0;
                    done           <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

`ifdef EDGE_GATE_TIMESTAMP_EN
    logic [31:0] ts_count;
    logic [31:0] gate_ts;

    // Free-running timestamp; ARM captures the value the first GATE cycle sees
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            ts_count <= 32'd0;
            gate_ts  <= 32'd0;
        end else begin
            ts_count <= ts_count + 32'd1;
            if ((state == ARM) && !abort) begin
                gate_ts <= ts_count + 32'd1;
            end
        end
    end

    assign push_entry = {gate_ts, count_1, count_0};
    assign fifo_rd_ts = head[95:64];
`else
    assign push_entry = {count_1, count_0};
`endif

    // Pointers carry one extra wrap bit to tell full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = fifo_rd && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push    = push_req && (!fifo_full || pop);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign fifo_rd_data = head[63:0];

    // Snapshot FIFO storage, pointers and sticky overflow. Storage is
    // cleared on reset so the head output reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (start_accept) begin
                overflow <= 1'b0;
            end else if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
